if_fetch_pc_unit: RTL and testbench

- Instruction-fetch front end of the pipelined CPU.
- Owns the fetch PC and drives the I-cache request/ready handshake.
- Takes the redirect target that the 32-bit 2:1 next-PC select produces downstream of branch resolution.
- Delivers {valid, pc, inst} into the IF/ID register, honouring back-end stall and redirect.
- Buffers one returned instruction during stall and drains in-flight misses on redirect.

---
 rtl/if_fetch_pc_unit_if.sv | 25 ++
 rtl/if_fetch_pc_unit.sv | 136 +++++++++++++
 tb/tb_if_fetch_pc_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pc_unit_if.sv
// Fetch-unit bus: back-end control, I-cache request/response and the IF/ID output register.
// Handshake: ic_req/ic_addr are held stable until the cycle ic_ready is high; ic_rdata is valid only in that cycle.
interface if_fetch_pc_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic [31:0] ic_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_misalign;

    modport slave (
        input  stall, redirect_valid, redirect_pc, ic_ready, ic_rdata,
        output ic_req, ic_addr, if_valid, if_pc, if_inst, if_misalign
    );

    modport master (
        output stall, redirect_valid, redirect_pc, ic_ready, ic_rdata,
        input  ic_req, ic_addr, if_valid, if_pc, if_inst, if_misalign
    );
endinterface

// File: rtl/if_fetch_pc_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives the I-cache request and
// loads {valid, pc, inst} into IF/ID, buffering one word on stall and draining misses on redirect.
module if_fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    if_fetch_pc_unit_if.slave         bus,
    output logic [1:0]                state_o
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_misalign_q, if_misalign_d;

    logic [31:0] redir_aligned;
    logic        redir_misaligned;

    assign redir_aligned    = {bus.redirect_pc[31:2], 2'b00};
    assign redir_misaligned = (bus.redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        hold_buf_d    = hold_buf_q;
        pend_pc_d     = pend_pc_q;
        // With stall low the output register reloads; bubble unless something is delivered below.
        if_valid_d    = bus.stall ? if_valid_q : 1'b0;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;
        if_misalign_d = 1'b0;

        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (bus.redirect_valid) begin
                    if_valid_d    = 1'b0;
                    if_misalign_d = redir_misaligned;
                    if (bus.ic_ready) begin
                        fetch_pc_d = redir_aligned;
                    end else begin
                        pend_pc_d = redir_aligned;
                        state_d   = ST_DRAIN;
                    end
                end else if (bus.ic_ready && !bus.stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = fetch_pc_q;
                    if_inst_d  = bus.ic_rdata;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end else if (bus.ic_ready) begin
                    hold_buf_d = bus.ic_rdata;
                    state_d    = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (bus.redirect_valid) begin
                    if_valid_d    = 1'b0;
                    if_misalign_d = redir_misaligned;
                    fetch_pc_d    = redir_aligned;
                    state_d       = ST_FETCH;
                end else if (!bus.stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = fetch_pc_q;
                    if_inst_d  = hold_buf_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // The abandoned miss must complete before the new target can be requested.
                if_valid_d = 1'b0;
                if (bus.redirect_valid) begin
                    if_misalign_d = redir_misaligned;
                    pend_pc_d     = redir_aligned;
                end
                if (bus.ic_ready) begin
                    fetch_pc_d = bus.redirect_valid ? redir_aligned : pend_pc_q;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST;
            fetch_pc_q    <= RESET_PC;
            hold_buf_q    <= 32'd0;
            pend_pc_q     <= 32'd0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_inst_q     <= 32'd0;
            if_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            hold_buf_q    <= hold_buf_d;
            pend_pc_q     <= pend_pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
            if_misalign_q <= if_misalign_d;
        end
    end

    // DRAIN keeps presenting the original fetch_pc, so ic_addr is simply the fetch PC.
    assign bus.ic_req      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign bus.ic_addr     = fetch_pc_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_inst     = if_inst_q;
    assign bus.if_misalign = if_misalign_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_if_fetch_pc_unit.sv
// Bench for if_fetch_pc_unit: directed fetch scenarios with an expected-delivery queue
// checked whenever IF/ID loads a new instruction.
module tb_if_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [1:0]  S_RST = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2, S_DRAIN = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_o;
    logic       stall_at_edge;
    int         n_checks;
    int         n_errors;
    logic [63:0] exp_q[$];

    if_fetch_pc_unit_if bus ();

    if_fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed time %0t, required < 200000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        inst_of = {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.ic_rdata = inst_of(bus.ic_addr);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back({pc, inst_of(pc)});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) stall_at_edge = bus.stall;

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && bus.if_valid && !stall_at_edge) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'd0, bus.if_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("if_pc", bus.if_pc, e[63:32]);
                check("if_inst", bus.if_inst, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.ic_ready       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_ic_req", {31'd0, bus.ic_req}, 32'd0);
        check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_if_pc", bus.if_pc, 32'd0);
        check("rst_if_inst", bus.if_inst, 32'd0);
        check("rst_if_misalign", {31'd0, bus.if_misalign}, 32'd0);
        check("rst_state", {30'd0, state_o}, {30'd0, S_RST});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        bus.ic_ready = 1'b0;
        bus.stall    = 1'b0;
        repeat (3) step();
        check(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        stall_at_edge = 1'b1;
        rst_n = 1'b0;
        idle_inputs();

        // 1: sustained hits from RESET_PC
        do_reset();
        step();
        check("t1_req", {31'd0, bus.ic_req}, 32'd1);
        check("t1_addr0", bus.ic_addr, 32'h1000);
        bus.ic_ready = 1'b1;
        expect_pc(32'h1000);
        step();
        check("t1_addr1", bus.ic_addr, 32'h1004);
        check("t1_valid1", {31'd0, bus.if_valid}, 32'd1);
        expect_pc(32'h1004);
        step();
        check("t1_addr2", bus.ic_addr, 32'h1008);
        check("t1_valid2", {31'd0, bus.if_valid}, 32'd1);
        expect_pc(32'h1008);
        step();
        check("t1_valid3", {31'd0, bus.if_valid}, 32'd1);
        drain("t1_queue");

        // 2: five-cycle miss at 0x1004
        do_reset();
        step();
        bus.ic_ready = 1'b1;
        expect_pc(32'h1000);
        step();
        check("t2_addr", bus.ic_addr, 32'h1004);
        bus.ic_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_addr_stable", bus.ic_addr, 32'h1004);
            check("t2_req", {31'd0, bus.ic_req}, 32'd1);
            check("t2_bubble", {31'd0, bus.if_valid}, 32'd0);
        end
        bus.ic_ready = 1'b1;
        expect_pc(32'h1004);
        step();
        check("t2_valid", {31'd0, bus.if_valid}, 32'd1);
        drain("t2_queue");

        // 3: stall at 0x2000 captures word in hold buffer
        do_reset();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1FFC;
        bus.ic_ready       = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check("t3_redir_addr", bus.ic_addr, 32'h1FFC);
        check("t3_redir_valid", {31'd0, bus.if_valid}, 32'd0);
        expect_pc(32'h1FFC);
        step();
        check("t3_addr", bus.ic_addr, 32'h2000);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_state", {30'd0, state_o}, {30'd0, S_HOLD});
            check("t3_req", {31'd0, bus.ic_req}, 32'd0);
            check("t3_frozen_valid", {31'd0, bus.if_valid}, 32'd1);
            check("t3_frozen_pc", bus.if_pc, 32'h1FFC);
        end
        bus.stall    = 1'b0;
        bus.ic_ready = 1'b0;
        expect_pc(32'h2000);
        step();
        check("t3_next_addr", bus.ic_addr, 32'h2004);
        check("t3_next_req", {31'd0, bus.ic_req}, 32'd1);
        drain("t3_queue");

        // 4: two redirects during a miss on 0x1008
        do_reset();
        step();
        bus.ic_ready = 1'b1;
        expect_pc(32'h1000);
        expect_pc(32'h1004);
        repeat (2) step();
        check("t4_addr", bus.ic_addr, 32'h1008);
        bus.ic_ready = 1'b0;
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3000;
        step();
        check("t4_drain", {30'd0, state_o}, {30'd0, S_DRAIN});
        bus.redirect_pc = 32'h4000;
        step();
        bus.redirect_valid = 1'b0;
        check("t4_drain_addr", bus.ic_addr, 32'h1008);
        check("t4_drain_req", {31'd0, bus.ic_req}, 32'd1);
        check("t4_drain_valid", {31'd0, bus.if_valid}, 32'd0);
        bus.ic_ready = 1'b1;
        step();
        bus.ic_ready = 1'b0;
        check("t4_target", bus.ic_addr, 32'h4000);
        check("t4_no_valid", {31'd0, bus.if_valid}, 32'd0);
        drain("t4_queue");

        // 5: misaligned redirect while in HOLD under stall
        do_reset();
        step();
        bus.ic_ready = 1'b1;
        expect_pc(32'h1000);
        step();
        bus.stall = 1'b1;
        step();
        check("t5_hold", {30'd0, state_o}, {30'd0, S_HOLD});
        check("t5_held_valid", {31'd0, bus.if_valid}, 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h5006;
        step();
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        bus.ic_ready       = 1'b0;
        check("t5_addr", bus.ic_addr, 32'h5004);
        check("t5_misalign", {31'd0, bus.if_misalign}, 32'd1);
        check("t5_valid", {31'd0, bus.if_valid}, 32'd0);
        step();
        check("t5_misalign_end", {31'd0, bus.if_misalign}, 32'd0);
        drain("t5_queue");

        // 6: asynchronous reset mid-miss and mid-HOLD
        do_reset();
        step();
        step();
        check("t6_miss_req", {31'd0, bus.ic_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req", {31'd0, bus.ic_req}, 32'd0);
        check("t6_async_state", {30'd0, state_o}, {30'd0, S_RST});
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("t6_restart_req", {31'd0, bus.ic_req}, 32'd1);
        check("t6_restart_addr", bus.ic_addr, RST_PC);
        bus.ic_ready = 1'b1;
        expect_pc(RST_PC);
        step();
        bus.stall = 1'b1;
        step();
        check("t6_hold", {30'd0, state_o}, {30'd0, S_HOLD});
        check("t6_hold_valid", {31'd0, bus.if_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, bus.if_valid}, 32'd0);
        check("t6_async_req2", {31'd0, bus.ic_req}, 32'd0);
        check("t6_async_misalign", {31'd0, bus.if_misalign}, 32'd0);
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("t6_restart_addr2", bus.ic_addr, RST_PC);
        drain("t6_queue");

        // 7: PC wraps past 0xFFFF_FFFC
        do_reset();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        bus.ic_ready       = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check("t7_addr", bus.ic_addr, 32'hFFFF_FFFC);
        check("t7_aligned_no_pulse", {31'd0, bus.if_misalign}, 32'd0);
        expect_pc(32'hFFFF_FFFC);
        step();
        check("t7_wrap", bus.ic_addr, 32'd0);
        drain("t7_queue");

        // 8: random hit/miss/stall traffic from reset, in-order delivery
        do_reset();
        step();
        for (int i = 0; i < 200; i++) begin
            bus.ic_ready = ($urandom_range(0, 3) != 0);
            bus.stall    = ($urandom_range(0, 4) == 0);
            if ((state_o == S_FETCH && bus.ic_ready && !bus.stall) ||
                (state_o == S_HOLD && !bus.stall)) begin
                expect_pc(bus.ic_addr);
            end
            step();
        end
        drain("t8_queue");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
